// File: rtl/cpu_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit Von Neumann CPU.
// Owns PC, IR, ACC, OPND and FLAGS; drives one shared RAM port and the external ALU.
module cpu_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  output logic [15:0] mem_addr_o,
  output logic [7:0]  mem_wdata_o,
  output logic        mem_we_o,
  input  logic [7:0]  mem_rdata_i,
  output logic [3:0]  alu_op_o,
  output logic [7:0]  alu_a_o,
  output logic [7:0]  alu_b_o,
  output logic [7:0]  alu_flags_o,
  input  logic [7:0]  alu_c_i,
  input  logic [7:0]  alu_new_flags_i,
  output logic [15:0] pc_o,
  output logic [7:0]  acc_o,
  output logic [7:0]  flags_o,
  output logic        halted_o,
  output logic        illegal_o
);

  typedef enum logic [3:0] {
    S_FETCH,
    S_FETCH_W,
    S_DECODE,
    S_ARG_LO,
    S_ARG_LO_W,
    S_ARG_HI,
    S_ARG_HI_W,
    S_MEM_RD,
    S_MEM_RD_W,
    S_MEM_WR,
    S_EXEC,
    S_HALT
  } state_t;

  localparam logic [3:0] CLS_NOP  = 4'h0;
  localparam logic [3:0] CLS_LDI  = 4'h1;
  localparam logic [3:0] CLS_LD   = 4'h2;
  localparam logic [3:0] CLS_ST   = 4'h3;
  localparam logic [3:0] CLS_JMP  = 4'h4;
  localparam logic [3:0] CLS_JEQ  = 4'h5;
  localparam logic [3:0] CLS_JGT  = 4'h6;
  localparam logic [3:0] CLS_ALUM = 4'h7;
  localparam logic [3:0] CLS_ALUI = 4'h8;
  localparam logic [3:0] CLS_HLT  = 4'hF;
  localparam logic [3:0] OP_CMP   = 4'h6;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  ir_q, ir_d;
  logic [7:0]  acc_q, acc_d;
  logic [7:0]  opnd_q, opnd_d;
  logic [7:0]  flags_q, flags_d;
  logic [7:0]  lo_q, lo_d;
  logic [7:0]  hi_q, hi_d;
  logic        illegal_q, illegal_d;

  logic [3:0]  cls;
  logic        bad_op;
  logic [15:0] target;

  assign cls    = ir_q[7:4];
  assign bad_op = ((cls >= 4'h9) && (cls <= 4'hE)) ||
                  (((cls == CLS_ALUM) || (cls == CLS_ALUI)) && (ir_q[3:0] > 4'd6));
  // Jump/operand address assembled from the latched lo byte and the hi byte arriving now
  assign target = {mem_rdata_i, lo_q};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= 8'h00;
      acc_q     <= 8'h00;
      opnd_q    <= 8'h00;
      flags_q   <= 8'h00;
      lo_q      <= 8'h00;
      hi_q      <= 8'h00;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      flags_q   <= flags_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    flags_d   = flags_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    illegal_d = illegal_q;
    unique case (state_q)
      S_FETCH: begin
        if (en_i) state_d = S_FETCH_W;
      end
      S_FETCH_W: begin
        ir_d    = mem_rdata_i;
        pc_d    = pc_q + 16'd1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (bad_op) begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end else if (cls == CLS_NOP) begin
          state_d = S_FETCH;
        end else if (cls == CLS_HLT) begin
          state_d = S_HALT;
        end else begin
          state_d = S_ARG_LO;
        end
      end
      S_ARG_LO:   state_d = S_ARG_LO_W;
      S_ARG_LO_W: begin
        pc_d = pc_q + 16'd1;
        if (cls == CLS_LDI) begin
          acc_d   = mem_rdata_i;
          state_d = S_FETCH;
        end else if (cls == CLS_ALUI) begin
          opnd_d  = mem_rdata_i;
          state_d = S_EXEC;
        end else begin
          lo_d    = mem_rdata_i;
          state_d = S_ARG_HI;
        end
      end
      S_ARG_HI:   state_d = S_ARG_HI_W;
      S_ARG_HI_W: begin
        pc_d    = pc_q + 16'd1;
        hi_d    = mem_rdata_i;
        state_d = S_MEM_RD;
        if (cls == CLS_JMP) begin
          pc_d    = target;
          state_d = S_FETCH;
        end else if (cls == CLS_JEQ) begin
          if (flags_q[0]) pc_d = target;
          state_d = S_FETCH;
        end else if (cls == CLS_JGT) begin
          if (flags_q[1]) pc_d = target;
          state_d = S_FETCH;
        end else if (cls == CLS_ST) begin
          state_d = S_MEM_WR;
        end
      end
      S_MEM_RD:   state_d = S_MEM_RD_W;
      S_MEM_RD_W: begin
        if (cls == CLS_LD) begin
          acc_d   = mem_rdata_i;
          state_d = S_FETCH;
        end else begin
          opnd_d  = mem_rdata_i;
          state_d = S_EXEC;
        end
      end
      S_MEM_WR:   state_d = S_FETCH;
      S_EXEC: begin
        if (ir_q[3:0] == OP_CMP) flags_d = alu_new_flags_i;
        else                     acc_d   = alu_c_i;
        state_d = S_FETCH;
      end
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;
    endcase
  end

  // Only the data phases drive the operand address; every other state shows PC
  assign mem_addr_o  = ((state_q == S_MEM_RD) || (state_q == S_MEM_WR)) ? {hi_q, lo_q} : pc_q;
  assign mem_we_o    = (state_q == S_MEM_WR) && !rst_i;
  assign mem_wdata_o = acc_q;

  assign alu_op_o    = ir_q[3:0];
  assign alu_a_o     = acc_q;
  assign alu_b_o     = opnd_q;
  assign alu_flags_o = flags_q;

  assign pc_o        = pc_q;
  assign acc_o       = acc_q;
  assign flags_o     = flags_q;
  assign halted_o    = (state_q == S_HALT);
  assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_cpu_ctrl.sv
// Bench for cpu_ctrl: registered RAM and ALU stubs, directed vector table,
// hand-written corner sequences and random programs against an instruction-level model.
module tb_cpu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] memAddr;
  logic [7:0]  memWdata;
  logic        memWe;
  logic [7:0]  memRdata;
  logic [3:0]  aluOp;
  logic [7:0]  aluA, aluB, aluFlags, aluC, aluNewFlags;
  logic [15:0] pc;
  logic [7:0]  acc, flags;
  logic        halted, illegal;

  logic [15:0] memAddr2;
  logic [7:0]  memWdata2;
  logic        memWe2;
  logic [7:0]  memRdata2;
  logic [3:0]  aluOp2;
  logic [7:0]  aluA2, aluB2, aluFlags2;
  logic [15:0] pc2;
  logic [7:0]  acc2, flags2;
  logic        halted2, illegal2;

  logic [7:0]  mem [0:65535];
  logic [7:0]  refMem [0:255];
  logic        loadEn = 1'b0;
  logic        clearReq = 1'b0;
  logic [15:0] loadAddr = 16'h0000;
  logic [7:0]  loadData = 8'h00;
  int          weCount = 0;
  int          weInReset = 0;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [95:0] prog;
    int          len;
    logic [7:0]  expAcc;
    logic [7:0]  expFlags;
    logic [15:0] expPc;
    int          expCycles;
    logic        expIllegal;
    logic [15:0] chkAddr;
    logic [7:0]  chkVal;
  } vec_t;

  vec_t vecs [13];

  always #5 clk = ~clk;

  cpu_ctrl dut (
    .clk_i(clk), .rst_i(rst), .en_i(en),
    .mem_addr_o(memAddr), .mem_wdata_o(memWdata), .mem_we_o(memWe), .mem_rdata_i(memRdata),
    .alu_op_o(aluOp), .alu_a_o(aluA), .alu_b_o(aluB), .alu_flags_o(aluFlags),
    .alu_c_i(aluC), .alu_new_flags_i(aluNewFlags),
    .pc_o(pc), .acc_o(acc), .flags_o(flags), .halted_o(halted), .illegal_o(illegal)
  );

  cpu_ctrl #(.RESET_PC(16'hFFFF)) dut2 (
    .clk_i(clk), .rst_i(rst), .en_i(1'b1),
    .mem_addr_o(memAddr2), .mem_wdata_o(memWdata2), .mem_we_o(memWe2), .mem_rdata_i(memRdata2),
    .alu_op_o(aluOp2), .alu_a_o(aluA2), .alu_b_o(aluB2), .alu_flags_o(aluFlags2),
    .alu_c_i(8'h00), .alu_new_flags_i(8'h00),
    .pc_o(pc2), .acc_o(acc2), .flags_o(flags2), .halted_o(halted2), .illegal_o(illegal2)
  );

  function automatic logic [7:0] aluResult(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return ~a;
      default: return 8'h00;
    endcase
  endfunction

  // ALU stub seen by the main DUT
  always_comb begin
    aluC        = aluResult(aluOp, aluA, aluB);
    aluNewFlags = {6'b0, aluA > aluB, aluA == aluB};
  end

  // Registered RAM: read data appears the cycle after the address
  always @(posedge clk) begin
    if (clearReq) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (loadEn) begin
      mem[loadAddr] <= loadData;
    end else if (memWe) begin
      mem[memAddr] <= memWdata;
    end
    memRdata <= mem[memAddr];
  end

  // Second DUT sees NOPs at FFFF and in page 0, HLT anywhere else
  always @(posedge clk) begin
    memRdata2 <= ((memAddr2 == 16'hFFFF) || (memAddr2[15:8] == 8'h00)) ? 8'h00 : 8'hF0;
  end

  always @(negedge clk) begin
    if (memWe) weCount <= weCount + 1;
    if (memWe && rst) weInReset <= weInReset + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clearAll();
    clearReq = 1'b1;
    tick(1);
    clearReq = 1'b0;
    for (int i = 0; i < 256; i++) refMem[i] = 8'h00;
  endtask

  task automatic putByte(input logic [15:0] addr, input logic [7:0] data);
    refMem[addr[7:0]] = data;
    loadAddr = addr;
    loadData = data;
    loadEn   = 1'b1;
    tick(1);
    loadEn   = 1'b0;
  endtask

  task automatic doReset(input logic enVal);
    rst = 1'b1;
    en  = enVal;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic runUntilHalt(input int maxCyc, output int cyc);
    logic done;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < maxCyc) begin
      tick(1);
      cyc++;
      if (halted) done = 1'b1;
    end
    if (!done) checkOutput("halt_timeout", 32'(cyc), 32'(maxCyc + 1));
  endtask

  // Instruction-level interpreter over refMem
  task automatic refRun(output int cyc, output logic [15:0] rpc, output logic [7:0] racc,
                        output logic [7:0] rflags, output logic rill);
    logic [7:0]  op, b;
    logic [15:0] a, p1;
    logic        done;
    cyc = 0; rpc = 16'h0000; racc = 8'h00; rflags = 8'h00; rill = 1'b0; done = 1'b0;
    for (int step = 0; step < 500 && !done; step++) begin
      op  = refMem[rpc[7:0]];
      rpc = rpc + 16'd1;
      if ((op[7:4] >= 4'h9 && op[7:4] <= 4'hE) ||
          ((op[7:4] == 4'h7 || op[7:4] == 4'h8) && op[3:0] > 4'd6)) begin
        rill = 1'b1; cyc += 3; done = 1'b1;
      end else if (op[7:4] == 4'h0) begin
        cyc += 3;
      end else if (op[7:4] == 4'hF) begin
        cyc += 3; done = 1'b1;
      end else if (op[7:4] == 4'h1 || op[7:4] == 4'h8) begin
        b   = refMem[rpc[7:0]];
        rpc = rpc + 16'd1;
        if (op[7:4] == 4'h1) begin
          racc = b; cyc += 5;
        end else begin
          if (op[3:0] == 4'd6) rflags = {6'b0, racc > b, racc == b};
          else                 racc = aluResult(op[3:0], racc, b);
          cyc += 6;
        end
      end else begin
        p1  = rpc + 16'd1;
        a   = {refMem[p1[7:0]], refMem[rpc[7:0]]};
        rpc = rpc + 16'd2;
        case (op[7:4])
          4'h2: begin racc = refMem[a[7:0]]; cyc += 9; end
          4'h3: begin refMem[a[7:0]] = racc; cyc += 8; end
          4'h4: begin rpc = a; cyc += 7; end
          4'h5: begin if (rflags[0]) rpc = a; cyc += 7; end
          4'h6: begin if (rflags[1]) rpc = a; cyc += 7; end
          default: begin
            b = refMem[a[7:0]];
            if (op[3:0] == 4'd6) rflags = {6'b0, racc > b, racc == b};
            else                 racc = aluResult(op[3:0], racc, b);
            cyc += 10;
          end
        endcase
      end
    end
  endtask

  function automatic vec_t mkVec(input logic [95:0] prog, input int len, input logic [7:0] eAcc,
                                 input logic [7:0] eFlags, input logic [15:0] ePc, input int eCyc,
                                 input logic eIll, input logic [15:0] cAddr, input logic [7:0] cVal);
    vec_t v;
    v.prog = prog; v.len = len; v.expAcc = eAcc; v.expFlags = eFlags; v.expPc = ePc;
    v.expCycles = eCyc; v.expIllegal = eIll; v.chkAddr = cAddr; v.chkVal = cVal;
    return v;
  endfunction

  task automatic applyStimulus(input int idx, input vec_t v);
    int cyc;
    rst = 1'b1;
    clearAll();
    putByte(16'h0050, 8'h5A);
    for (int i = 0; i < v.len; i++) putByte(16'(i), v.prog[95 - 8*i -: 8]);
    doReset(1'b1);
    runUntilHalt(200, cyc);
    checkOutput($sformatf("vec%0d_cycles", idx), 32'(cyc), 32'(v.expCycles));
    checkOutput($sformatf("vec%0d_acc", idx), 32'(acc), 32'(v.expAcc));
    checkOutput($sformatf("vec%0d_flags", idx), 32'(flags), 32'(v.expFlags));
    checkOutput($sformatf("vec%0d_pc", idx), 32'(pc), 32'(v.expPc));
    checkOutput($sformatf("vec%0d_illegal", idx), 32'(illegal), 32'(v.expIllegal));
    checkOutput($sformatf("vec%0d_mem", idx), 32'(mem[v.chkAddr]), 32'(v.chkVal));
  endtask

  task automatic randomProgram(input int idx);
    logic [15:0] a;
    logic [7:0]  r;
    int          n, k, cyc, rCyc, bad;
    logic [15:0] rPc;
    logic [7:0]  rAcc, rFlags;
    logic        rIll;
    rst = 1'b1;
    clearAll();
    for (int i = 0; i < 16; i++) putByte(16'h0080 + 16'(i), 8'($urandom));
    a = 16'h0000;
    n = $urandom_range(4, 12);
    for (int i = 0; i < n; i++) begin
      k = $urandom_range(0, 8);
      r = 8'h80 + 8'($urandom_range(0, 15));
      case (k)
        0: begin putByte(a, 8'h00); a += 1; end
        1: begin putByte(a, 8'h10); putByte(a + 1, 8'($urandom)); a += 2; end
        2, 3: begin
          putByte(a, (k == 2) ? 8'h20 : 8'h30); putByte(a + 1, r); putByte(a + 2, 8'h00); a += 3;
        end
        4, 5, 6: begin
          putByte(a, {4'(k), 4'h0}); putByte(a + 1, 8'(a + 5)); putByte(a + 2, 8'h00);
          putByte(a + 3, 8'h10); putByte(a + 4, 8'($urandom)); a += 5;
        end
        7: begin
          putByte(a, {4'h7, 4'($urandom_range(0, 6))}); putByte(a + 1, r); putByte(a + 2, 8'h00); a += 3;
        end
        default: begin
          putByte(a, {4'h8, 4'($urandom_range(0, 6))}); putByte(a + 1, 8'($urandom)); a += 2;
        end
      endcase
    end
    putByte(a, 8'hF0);
    doReset(1'b1);
    runUntilHalt(2000, cyc);
    refRun(rCyc, rPc, rAcc, rFlags, rIll);
    bad = 0;
    for (int i = 0; i < 16; i++) if (mem[16'h0080 + 16'(i)] !== refMem[8'h80 + 8'(i)]) bad++;
    checkOutput($sformatf("rnd%0d_cycles", idx), 32'(cyc), 32'(rCyc));
    checkOutput($sformatf("rnd%0d_pc", idx), 32'(pc), 32'(rPc));
    checkOutput($sformatf("rnd%0d_acc", idx), 32'(acc), 32'(rAcc));
    checkOutput($sformatf("rnd%0d_flags", idx), 32'(flags), 32'(rFlags));
    checkOutput($sformatf("rnd%0d_illegal", idx), 32'(illegal), 32'(rIll));
    checkOutput($sformatf("rnd%0d_datamem_bad", idx), 32'(bad), 32'd0);
  endtask

  initial begin
    int weBefore;
    rst = 1'b1;
    en  = 1'b1;

    vecs[0]  = mkVec(96'h1005_8003_3040_00F0_0000_0000,  8, 8'h08, 8'h00, 16'h0008, 22, 1'b0, 16'h0040, 8'h08);
    vecs[1]  = mkVec(96'h1007_8607_500A_0010_11F0_F000, 11, 8'h07, 8'h01, 16'h000B, 21, 1'b0, 16'h0050, 8'h5A);
    vecs[2]  = mkVec(96'h1007_8603_500A_0010_11F0_F000, 11, 8'h11, 8'h02, 16'h000A, 26, 1'b0, 16'h0050, 8'h5A);
    vecs[3]  = mkVec(96'h1009_8604_600A_0010_11F0_F000, 11, 8'h09, 8'h02, 16'h000B, 21, 1'b0, 16'h0050, 8'h5A);
    vecs[4]  = mkVec(96'h4005_00F0_F020_5000_F000_0000,  9, 8'h5A, 8'h00, 16'h0009, 19, 1'b0, 16'h0050, 8'h5A);
    vecs[5]  = mkVec(96'h1060_7150_00F0_0000_0000_0000,  6, 8'h06, 8'h00, 16'h0006, 18, 1'b0, 16'h0050, 8'h5A);
    vecs[6]  = mkVec(96'h100F_8533_F000_0000_0000_0000,  5, 8'hF0, 8'h00, 16'h0005, 14, 1'b0, 16'h0050, 8'h5A);
    vecs[7]  = mkVec(96'h10F0_84FF_823C_F000_0000_0000,  7, 8'h0C, 8'h00, 16'h0007, 20, 1'b0, 16'h0050, 8'h5A);
    vecs[8]  = mkVec(96'h9000_0000_0000_0000_0000_0000,  1, 8'h00, 8'h00, 16'h0001,  3, 1'b1, 16'h0050, 8'h5A);
    vecs[9]  = mkVec(96'h1005_8701_0000_0000_0000_0000,  4, 8'h05, 8'h00, 16'h0003,  8, 1'b1, 16'h0050, 8'h5A);
    vecs[10] = mkVec(96'h0000_F000_0000_0000_0000_0000,  3, 8'h00, 8'h00, 16'h0003,  9, 1'b0, 16'h0050, 8'h5A);
    vecs[11] = mkVec(96'h1050_830A_F000_0000_0000_0000,  5, 8'h5A, 8'h00, 16'h0005, 14, 1'b0, 16'h0050, 8'h5A);
    vecs[12] = mkVec(96'h103C_3060_0010_0020_6000_F000, 11, 8'h3C, 8'h00, 16'h000B, 30, 1'b0, 16'h0060, 8'h3C);

    $display("[TB] start");
    tick(2);

    for (int i = 0; i < 13; i++) applyStimulus(i, vecs[i]);

    // Reset values and RESET_PC wrap on the second instance
    doReset(1'b1);
    checkOutput("reset_pc", 32'(pc), 32'h0000);
    checkOutput("reset_acc", 32'(acc), 32'h00);
    checkOutput("reset_halted", 32'(halted), 32'h0);
    checkOutput("wrap_pc_reset", 32'(pc2), 32'hFFFF);
    tick(2);
    checkOutput("wrap_pc_after_fetch", 32'(pc2), 32'h0000);
    tick(3);
    checkOutput("wrap_pc_after_nop", 32'(pc2), 32'h0001);
    checkOutput("wrap_not_halted", 32'(halted2), 32'h0);

    // Illegal class with en toggling: halts, never writes
    rst = 1'b1;
    clearAll();
    putByte(16'h0000, 8'h90);
    doReset(1'b1);
    weBefore = weCount;
    for (int i = 0; i < 20; i++) begin
      en = (i >= 10) ? 1'b1 : 1'($urandom_range(0, 1));
      tick(1);
    end
    checkOutput("illegal_flag", 32'(illegal), 32'h1);
    checkOutput("illegal_halted", 32'(halted), 32'h1);
    checkOutput("illegal_pc", 32'(pc), 32'h0001);
    checkOutput("illegal_addr", 32'(memAddr), 32'h0001);
    checkOutput("illegal_no_we", 32'(weCount - weBefore), 32'h0);

    // Reset asserted during MEM_WR of ST 0x0010
    rst = 1'b1;
    clearAll();
    putByte(16'h0000, 8'h30);
    putByte(16'h0001, 8'h10);
    putByte(16'h0002, 8'h00);
    putByte(16'h0010, 8'hAA);
    doReset(1'b1);
    tick(7);
    checkOutput("st_we_in_memwr", 32'(memWe), 32'h1);
    checkOutput("st_addr_in_memwr", 32'(memAddr), 32'h0010);
    rst = 1'b1;
    #1;
    checkOutput("st_we_gated_by_rst", 32'(memWe), 32'h0);
    @(posedge clk);
    #1;
    checkOutput("st_mem_unchanged", 32'(mem[16'h0010]), 32'hAA);
    checkOutput("st_pc_after_rst", 32'(pc), 32'h0000);
    rst = 1'b0;
    tick(2);
    checkOutput("st_refetch_pc", 32'(pc), 32'h0001);

    // Hold in FETCH while en=0, then one NOP
    rst = 1'b1;
    clearAll();
    putByte(16'h0000, 8'h03);
    doReset(1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      checkOutput($sformatf("hold_pc_%0d", i), 32'(pc), 32'h0000);
      checkOutput($sformatf("hold_ir_%0d", i), 32'(aluOp), 32'h0);
    end
    en = 1'b1;
    tick(3);
    checkOutput("nop_pc", 32'(pc), 32'h0001);
    checkOutput("nop_ir", 32'(aluOp), 32'h3);
    checkOutput("nop_fetch_addr", 32'(memAddr), 32'h0001);

    for (int i = 0; i < 20; i++) randomProgram(i);

    checkOutput("we_during_reset", 32'(weInReset), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
